instr_buffer: RTL and testbench

Circular instruction buffer between the IF1 stage and decode. Accepts up to four fetched instruction entries per cycle from IF1 (`if1_to_ib` / `push_num`), reports its occupancy back as `can_push_size` for IF1's flow control, and presents the oldest entries to decode, which retires up to two per cycle with `pop_num`. Program order is preserved across wrap-around. `flush` empties the buffer.

---
 rtl/instr_buffer_pkg.sv | 25 ++
 rtl/instr_buffer_mem.sv | 43 ++++
 rtl/instr_buffer.sv | 127 ++++++++++++
 tb/tb_instr_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/instr_buffer_pkg.sv
// instr_buffer_pkg
// Shared constants for the IF1 -> decode instruction buffer.
//   IB_WIDTH_LOG2    : log2 of the buffer depth (16 entries)
//   IB_DATA_BUS_WD   : width of one entry
//   IB_*_LSB / _BIT  : entry field positions
//     layout {pc_valid, is_jump, in_excp, Ecode[5:0], subEcode[8:0], pc[31:0], instr[31:0]}
//   IB_LANES         : push lanes from IF1
//   IB_POP_WD        : width of the decode pop count
package instr_buffer_pkg;

  localparam int IB_WIDTH_LOG2   = 4;
  localparam int IB_DATA_BUS_WD  = 82;

  localparam int IB_INSTR_LSB    = 0;
  localparam int IB_PC_LSB       = 32;
  localparam int IB_SUBECODE_LSB = 64;
  localparam int IB_ECODE_LSB    = 73;
  localparam int IB_IN_EXCP_BIT  = 79;
  localparam int IB_IS_JUMP_BIT  = 80;
  localparam int IB_PC_VALID_BIT = 81;

  localparam int IB_LANES        = 4;
  localparam int IB_POP_WD       = 2;

endpackage

// File: rtl/instr_buffer_mem.sv
// ib_mem
// Entry storage for instr_buffer: DEPTH x DATA_WD, not reset.
//   clk      : clock
//   wr_base  : address of write lane 0; lane k goes to wr_base+k (modulo DEPTH)
//   wr_num   : number of write lanes enabled this cycle (0..4)
//   wr_data  : four write lanes, lane k at [(k+1)*DATA_WD-1 : k*DATA_WD]
//   rd_base  : address of read lane 0; lane 1 reads rd_base+1
//   rd_data  : two combinational read lanes
module ib_mem
  import instr_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = IB_WIDTH_LOG2,
  parameter int DATA_WD    = IB_DATA_BUS_WD
) (
  input  logic                        clk,
  input  logic [DEPTH_LOG2-1:0]       wr_base,
  input  logic [2:0]                  wr_num,
  input  logic [IB_LANES*DATA_WD-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0]       rd_base,
  output logic [2*DATA_WD-1:0]        rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;

  logic [DATA_WD-1:0] mem_r [DEPTH];

  // Write the first wr_num lanes at consecutive addresses from wr_base.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IB_LANES; k++) begin
      if (3'(k) < wr_num) begin
        mem_r[wr_base + AW'(k)] <= wr_data[k*DATA_WD +: DATA_WD];
      end
    end
  end

  // Combinational read of the two oldest slots; reads see the pre-edge array.
  always_comb begin
    rd_data[DATA_WD-1:0]         = mem_r[rd_base];
    rd_data[2*DATA_WD-1:DATA_WD] = mem_r[rd_base + AW'(1)];
  end

endmodule

// File: rtl/instr_buffer.sv
// instr_buffer
// Circular instruction buffer between IF1 and decode. Accepts up to four
// entries per cycle, presents the two oldest to decode, preserves program
// order across wrap-around.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : synchronous clear, wins over push and pop
//   if1_to_ib      : four push lanes, lane 0 oldest
//   push_num       : lanes to write (0..4); whole push dropped if it does not fit
//   can_push_size  : registered occupancy count (0..DEPTH)
//   out_data       : lane 0 = head, lane 1 = head+1
//   out_valid      : lane valid bits (00, 01, 11)
//   pop_num        : entries retired by decode (0..2), clamped to occupancy
// Build option: IB_DUAL_ISSUE_EN enables two-wide pop; when undefined, lane 1
// is never valid and at most one entry is popped per cycle.
module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = IB_WIDTH_LOG2,
  parameter int DATA_WD    = IB_DATA_BUS_WD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [IB_LANES*DATA_WD-1:0] if1_to_ib,
  input  logic [2:0]                  push_num,
  output logic [DEPTH_LOG2:0]         can_push_size,
  output logic [2*DATA_WD-1:0]        out_data,
  output logic [1:0]                  out_valid,
  input  logic [IB_POP_WD-1:0]        pop_num
);

  localparam int AW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int SW = DEPTH_LOG2 + 2;
  localparam logic [SW-1:0] DEPTH_V = {1'b0, 1'b1, {DEPTH_LOG2{1'b0}}};

  logic [AW-1:0]        head_r;
  logic [AW-1:0]        tail_r;
  logic [CW-1:0]        count_r;

  logic [IB_POP_WD-1:0] pop_req_s;
  logic [IB_POP_WD-1:0] pop_eff_s;
  logic [CW-1:0]        count_eff_s;
  logic [SW-1:0]        push_total_s;
  logic [2:0]           push_acc_s;
  logic [2*DATA_WD-1:0] rd_data_s;

  // Pop request limited by issue width, then by the number of valid entries.
  always_comb begin
`ifdef IB_DUAL_ISSUE_EN
    if (pop_num > 2'd2) begin
      pop_req_s = 2'd2;
    end else begin
      pop_req_s = pop_num;
    end
`else
    if (pop_num != 2'd0) begin
      pop_req_s = 2'd1;
    end else begin
      pop_req_s = 2'd0;
    end
`endif
    // Overshoot only happens when count < 2, so its low bits are exact.
    if (CW'(pop_req_s) > count_r) begin
      pop_eff_s = count_r[IB_POP_WD-1:0];
    end else begin
      pop_eff_s = pop_req_s;
    end
  end

  // Push is all-or-nothing, checked against occupancy after this cycle's pop.
  always_comb begin
    count_eff_s  = count_r - CW'(pop_eff_s);
    push_total_s = {1'b0, count_eff_s} + SW'(push_num);
    if (!flush && (push_num <= 3'd4) && (push_total_s <= DEPTH_V)) begin
      push_acc_s = push_num;
    end else begin
      push_acc_s = 3'd0;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      head_r  <= head_r + AW'(pop_eff_s);
      tail_r  <= tail_r + AW'(push_acc_s);
      count_r <= count_eff_s + CW'(push_acc_s);
    end
  end

  ib_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WD    (DATA_WD)
  ) u_ib_mem (
    .clk     (clk),
    .wr_base (tail_r),
    .wr_num  (push_acc_s),
    .wr_data (if1_to_ib),
    .rd_base (head_r),
    .rd_data (rd_data_s)
  );

  assign can_push_size = count_r;

  // Output lanes and their valid bits, derived from the registered count.
  always_comb begin
    out_valid[0] = (count_r != {CW{1'b0}});
`ifdef IB_DUAL_ISSUE_EN
    out_valid[1] = (count_r >= CW'(2));
    out_data     = rd_data_s;
`else
    // Second read port exists but its lane is forced to zero in single issue.
    out_valid[1] = 1'b0;
    out_data     = {rd_data_s[2*DATA_WD-1:DATA_WD] & {DATA_WD{1'b0}},
                    rd_data_s[DATA_WD-1:0]};
`endif
  end

endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer
// Scoreboard bench for instr_buffer: accepted pushes queue their entries,
// popped lanes are compared against the queue front before the edge.
module tb_instr_buffer;
  import instr_buffer_pkg::*;

  localparam int W     = IB_DATA_BUS_WD;
  localparam int DEPTH = 1 << IB_WIDTH_LOG2;
`ifdef IB_DUAL_ISSUE_EN
  localparam int MAXPOP = 2;
`else
  localparam int MAXPOP = 1;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush = 1'b0;
  logic [IB_LANES*W-1:0]    if1_to_ib = '0;
  logic [2:0]               push_num = 3'd0;
  logic [IB_WIDTH_LOG2:0]   can_push_size;
  logic [2*W-1:0]           out_data;
  logic [1:0]               out_valid;
  logic [IB_POP_WD-1:0]     pop_num = 2'd0;

  int          total = 0;
  int          bad   = 0;
  int          mcount = 0;
  logic [31:0] next_pc = 32'h0000_1000;
  logic [W-1:0] sb [$];

  instr_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .if1_to_ib     (if1_to_ib),
    .push_num      (push_num),
    .can_push_size (can_push_size),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .pop_num       (pop_num)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] make_entry(input logic [31:0] pc);
    logic [W-1:0] e;
    e = '0;
    e[IB_INSTR_LSB +: 32]   = pc ^ 32'hA5A5_5A5A;
    e[IB_PC_LSB +: 32]      = pc;
    e[IB_SUBECODE_LSB +: 9] = pc[10:2];
    e[IB_ECODE_LSB +: 6]    = pc[7:2];
    e[IB_IN_EXCP_BIT]       = pc[2];
    e[IB_IS_JUMP_BIT]       = pc[3];
    e[IB_PC_VALID_BIT]      = 1'b1;
    return e;
  endfunction

  function automatic logic [1:0] exp_valid(input int c);
    if (c >= 2 && MAXPOP == 2) return 2'b11;
    else if (c >= 1) return 2'b01;
    else return 2'b00;
  endfunction

  // One clock cycle: drive, compare popped lanes, update model, check state.
  task automatic step(input int pn, input int pp, input logic fl);
    int           pe;
    int           ce;
    logic         acc;
    logic [W-1:0] e;
    push_num = 3'(pn);
    pop_num  = 2'(pp);
    flush    = fl;
    for (int k = 0; k < IB_LANES; k++) begin
      if1_to_ib[k*W +: W] = make_entry(next_pc + 32'(4*k));
    end
    pe = (pp < mcount) ? pp : mcount;
    if (pe > MAXPOP) pe = MAXPOP;
    ce  = mcount - pe;
    acc = (ce + pn <= DEPTH) && !fl;
    if (fl) begin
      sb.delete();
      mcount = 0;
    end else begin
      for (int i = 0; i < pe; i++) begin
        e = sb.pop_front();
        check_val("pop_lane", out_data[i*W +: W], e);
      end
      if (acc) begin
        for (int k = 0; k < pn; k++) sb.push_back(make_entry(next_pc + 32'(4*k)));
        next_pc = next_pc + 32'(4*pn);
        mcount  = ce + pn;
      end else begin
        mcount = ce;
      end
    end
    @(posedge clk);
    #1;
    check_val("count", W'(can_push_size), W'(mcount));
    check_val("valid", W'(out_valid), W'(exp_valid(mcount)));
    if (mcount >= 1) check_val("head", out_data[W-1:0], sb[0]);
`ifndef IB_DUAL_ISSUE_EN
    check_val("lane1_zero", out_data[2*W-1:W], '0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    check_val("rst_count", W'(can_push_size), '0);
    check_val("rst_valid", W'(out_valid), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill and order
    step(4, 0, 1'b0);
    step(4, 0, 1'b0);
    step(4, 0, 1'b0);
    check_val("fill_count", W'(can_push_size), W'(12));
    check_val("fill_pc", W'(out_data[IB_PC_LSB +: 32]), W'(32'h0000_1000));
    step(0, 0, 1'b1);

    // Wrap: push 3 / pop 2 repeatedly
    for (int n = 0; n < 40; n++) step(3, 2, 1'b0);
    step(0, 0, 1'b1);

    // Overflow
    step(4, 0, 1'b0);
    step(4, 0, 1'b0);
    step(4, 0, 1'b0);
    step(2, 0, 1'b0);
    step(4, 0, 1'b0);
    check_val("ovf_drop", W'(can_push_size), W'(14));
    step(4, 2, 1'b0);
`ifdef IB_DUAL_ISSUE_EN
    check_val("ovf_accept", W'(can_push_size), W'(16));
`else
    check_val("ovf_single", W'(can_push_size), W'(13));
`endif
    step(0, 0, 1'b1);

    // Clamp and simultaneous push/pop
    step(1, 0, 1'b0);
    step(2, 2, 1'b0);
    check_val("clamp_count", W'(can_push_size), W'(2));
`ifdef IB_DUAL_ISSUE_EN
    check_val("clamp_valid", W'(out_valid), W'(2'b11));
`else
    check_val("clamp_valid", W'(out_valid), W'(2'b01));
`endif
    step(0, 0, 1'b1);

    // Flush with push and pop asserted
    step(4, 0, 1'b0);
    step(4, 0, 1'b0);
    step(1, 0, 1'b0);
    step(4, 2, 1'b1);
    check_val("flush_count", W'(can_push_size), W'(0));
    check_val("flush_valid", W'(out_valid), W'(2'b00));

    // Pop 2 at count 5
    step(4, 0, 1'b0);
    step(1, 0, 1'b0);
    step(0, 2, 1'b0);
`ifdef IB_DUAL_ISSUE_EN
    check_val("pop2_count", W'(can_push_size), W'(3));
`else
    check_val("pop2_count", W'(can_push_size), W'(4));
`endif
    step(0, 0, 1'b1);

    // Asynchronous reset mid-stream at count 7
    step(4, 0, 1'b0);
    step(3, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_count", W'(can_push_size), '0);
    check_val("arst_valid", W'(out_valid), '0);
    sb.delete();
    mcount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1'b0);
    step(2, 0, 1'b0);
    step(0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
